// File: rtl/hilo_muldiv_seq.sv
// hilo_muldiv_seq: multi-cycle radix-2 shift-add multiplier that owns HI/LO.
// Serves MUL/MULT/MULTU/MADD/MSUB plus MTHI/MTLO/MFHI/MFLO and stalls on
// HI/LO hazards. Optional build macro: EARLY_TERM_EN (leave CALC as soon
// as the remaining multiplier bits are all zero; results are unchanged).
//
// Handshake: an op is offered while op_valid=1. While stall=1 the pipeline
// keeps op_valid/ALUcnt/A/B stable and re-offers the same op next cycle; an
// op offered with stall=0 is consumed at that clock edge. flush kills
// whatever is offered or in flight and always wins.
module hilo_muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             op_valid,
   input  logic [5:0]       ALUcnt,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             flush,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] mul_result,
   output logic [WIDTH-1:0] hilo_rdata,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic [1:0]       dbg_state
);

   localparam logic [5:0] OP_MUL   = 6'b000010;
   localparam logic [5:0] OP_MULTU = 6'b000011;
   localparam logic [5:0] OP_MADD  = 6'b000100;
   localparam logic [5:0] OP_MSUB  = 6'b000101;
   localparam logic [5:0] OP_MULT  = 6'b011000;
   localparam logic [5:0] OP_MTHI  = 6'b010100;
   localparam logic [5:0] OP_MTLO  = 6'b010101;
   localparam logic [5:0] OP_MFHI  = 6'b010110;
   localparam logic [5:0] OP_MFLO  = 6'b010111;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_t;

   state_t              state, state_nx;
   logic [WIDTH-1:0]    mcand, mrem, mplier, acc_hi;
   logic [CW-1:0]       cnt;
   logic                neg_q, mul_retire;
   logic [5:0]          op_q;
   logic [WIDTH-1:0]    hi_q, lo_q;

   logic                is_mul, is_mult_cls, is_hilo_cls, is_signed_op;
   logic                accept, iter_last, idle_wr;
   logic [WIDTH-1:0]    a_mag, b_mag, addend;
   logic [WIDTH:0]      sum;
   logic [2*WIDTH-1:0]  pair, raw, prod, hilo_cur;

   // Decode the presented ALU control code.
   always_comb begin
      is_mul       = (ALUcnt == OP_MUL);
      is_mult_cls  = is_mul || (ALUcnt == OP_MULTU) || (ALUcnt == OP_MADD) ||
                     (ALUcnt == OP_MSUB) || (ALUcnt == OP_MULT);
      is_hilo_cls  = is_mult_cls || (ALUcnt == OP_MTHI) || (ALUcnt == OP_MTLO) ||
                     (ALUcnt == OP_MFHI) || (ALUcnt == OP_MFLO);
      is_signed_op = is_mult_cls && (ALUcnt != OP_MULTU);
   end

   assign accept  = (state == S_IDLE) && op_valid && !flush && !mul_retire && is_mult_cls;
   assign idle_wr = (state == S_IDLE) && op_valid && !flush;
   assign a_mag   = (is_signed_op && A[WIDTH-1]) ? -A : A;
   assign b_mag   = (is_signed_op && B[WIDTH-1]) ? -B : B;

   // One shift-add step: add the multiplicand into the upper half when the
   // current multiplier bit is set; the carry lands in the next shift.
   assign addend = mrem[0] ? mcand : {WIDTH{1'b0}};
   assign sum    = {1'b0, acc_hi} + {1'b0, addend};

`ifdef EARLY_TERM_EN
   assign iter_last = (mrem[WIDTH-1:1] == '0) || (cnt == CW'(WIDTH - 1));
`else
   assign iter_last = (cnt == CW'(WIDTH - 1));
`endif

   // Realign the pair after an early exit, then apply the sign.
   always_comb begin
      pair = {acc_hi, mplier};
`ifdef EARLY_TERM_EN
      raw  = pair >> (CW'(WIDTH) - cnt);
`else
      raw  = pair;
`endif
      prod     = neg_q ? -raw : raw;
      hilo_cur = {hi_q, lo_q};
   end

   // State register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Next-state logic; flush aborts any in-flight multiply.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept) state_nx = S_CALC;
         S_CALC:  if (flush) state_nx = S_IDLE;
                  else if (iter_last) state_nx = S_FIX;
         S_FIX:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Multiplier datapath: load magnitudes on accept, iterate in CALC.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         mcand  <= '0;
         mrem   <= '0;
         mplier <= '0;
         acc_hi <= '0;
         cnt    <= '0;
         neg_q  <= 1'b0;
         op_q   <= '0;
      end else if (accept) begin
         mcand  <= a_mag;
         mrem   <= b_mag;
         mplier <= b_mag;
         acc_hi <= '0;
         cnt    <= '0;
         neg_q  <= is_signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
         op_q   <= ALUcnt;
      end else if (state == S_CALC && !flush) begin
         acc_hi <= sum[WIDTH:1];
         mplier <= {sum[0], mplier[WIDTH-1:1]};
         mrem   <= mrem >> 1;
         cnt    <= cnt + 1'b1;
      end
   end

   // HI/LO and MUL result commit, done pulse, and MUL retire marker.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         hi_q       <= '0;
         lo_q       <= '0;
         mul_result <= '0;
         done       <= 1'b0;
         mul_retire <= 1'b0;
      end else begin
         done       <= 1'b0;
         mul_retire <= 1'b0;
         if (state == S_FIX && !flush) begin
            done       <= 1'b1;
            mul_retire <= (op_q == OP_MUL);
            case (op_q)
               OP_MULT, OP_MULTU: {hi_q, lo_q} <= prod;
               OP_MADD:           {hi_q, lo_q} <= hilo_cur + prod;
               OP_MSUB:           {hi_q, lo_q} <= hilo_cur - prod;
               OP_MUL:            mul_result   <= prod[WIDTH-1:0];
               default:           ;
            endcase
         end else if (idle_wr) begin
            if (ALUcnt == OP_MTHI) hi_q <= A;
            if (ALUcnt == OP_MTLO) lo_q <= A;
         end
      end
   end

   // Read port and hazard stall.
   always_comb begin
      hilo_rdata = '0;
      if (op_valid && ALUcnt == OP_MFHI) hilo_rdata = hi_q;
      if (op_valid && ALUcnt == OP_MFLO) hilo_rdata = lo_q;
   end

   assign busy      = (state != S_IDLE);
   assign stall     = !Reset && op_valid &&
                      ((is_hilo_cls && busy) ||
                       (is_mul && state == S_IDLE && !flush && !mul_retire));
   assign HI        = hi_q;
   assign LO        = lo_q;
   assign dbg_state = state;

endmodule
